req_priority_encoder: RTL and testbench

- Sequential 4-to-2 priority encoder: the encode side of the team's 2-to-4 decoder (lines d3..d0 map to codes 3..0).
- Captures a request vector and issues the 2-bit code of each set line, one code per handshake, highest index first, over a valid/ready interface.
- Sits between request sources and any consumer of a binary index, such as a downstream 2-to-4 decoder driving select lines.

---
 rtl/req_priority_encoder.sv | 79 +++++++
 tb/tb_req_priority_encoder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/req_priority_encoder.sv
// Captures a request vector and issues one 2-bit code per valid/ready handshake, highest index first.
// First code one cycle after the load edge; code_out holds while code_ready is low; en=0 freezes everything.
module req_priority_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req_in,
  input  logic         req_load,
  output logic         busy,
  output logic [W-1:0] code_out,
  output logic         code_valid,
  input  logic         code_ready,
  output logic         none,
  output logic         overflow
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] top_onehot;
  logic [N-1:0] pending_nxt;

  // Later (higher) indices overwrite earlier ones, giving fixed priority 3>2>1>0.
  always_comb begin
    code_out   = '0;
    top_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        code_out      = W'(i);
        top_onehot    = '0;
        top_onehot[i] = 1'b1;
      end
    end
  end

  assign pending_nxt = pending & ~top_onehot;
  assign busy        = (state == SERVE);
  assign code_valid  = en && (state == SERVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      none     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      none     <= 1'b0;
      overflow <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (req_load) begin
              if (|req_in) begin
                pending <= req_in;
                state   <= SERVE;
              end else begin
                none <= 1'b1;
              end
            end
          end
          SERVE: begin
            // A load while serving is dropped, even on the final handshake.
            if (req_load) overflow <= 1'b1;
            if (code_ready) begin
              pending <= pending_nxt;
              if (pending_nxt == '0) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_req_priority_encoder.sv
// Directed vector table plus hand-written sequences for the priority encoder.
module tb_req_priority_encoder;

  logic       clk = 1'b0;
  logic       rst, en, req_load, code_ready;
  logic [3:0] req_in;
  logic       busy, code_valid, none, overflow;
  logic [1:0] code_out;

  int n_checks = 0;
  int n_fail   = 0;

  req_priority_encoder #(.N(4), .W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .req_in(req_in), .req_load(req_load),
    .busy(busy), .code_out(code_out), .code_valid(code_valid),
    .code_ready(code_ready), .none(none), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Each record: inputs applied for one cycle, and the outputs expected during that cycle.
  typedef struct {
    logic       r, e, ld;
    logic [3:0] rin;
    logic       rdy;
    logic       busy;
    logic [1:0] code;
    logic       vld, nn, ovf;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic ld, logic [3:0] rin, logic rdy,
                              logic b, logic [1:0] c, logic vl, logic nn, logic ov);
    vec_t v;
    v.r = r; v.e = e; v.ld = ld; v.rin = rin; v.rdy = rdy;
    v.busy = b; v.code = c; v.vld = vl; v.nn = nn; v.ovf = ov;
    return v;
  endfunction

  task automatic chk(input string tag, input string what, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %0d want %0d", tag, what, got, want);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.r; en = v.e; req_load = v.ld; req_in = v.rin; code_ready = v.rdy;
    #1;
    chk(tag, "busy", {3'b0, busy}, {3'b0, v.busy});
    chk(tag, "code_valid", {3'b0, code_valid}, {3'b0, v.vld});
    chk(tag, "none", {3'b0, none}, {3'b0, v.nn});
    chk(tag, "overflow", {3'b0, overflow}, {3'b0, v.ovf});
    // code_out is only meaningful when valid, or when nothing is pending (must be 0).
    if (v.vld || !v.busy) chk(tag, "code_out", {2'b0, code_out}, {2'b0, v.code});
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; en = 1'b0; req_load = 1'b0; req_in = 4'h0; code_ready = 1'b0;
    repeat (2) @(posedge clk);

    //            r  e  ld rin     rdy  busy code vld none ovf
    tbl.push_back(mk(0, 0, 0, 4'b0000, 0,  0, 2'd0, 0, 0, 0)); // reset values
    // basic 1010
    tbl.push_back(mk(0, 1, 1, 4'b1010, 1,  0, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  1, 2'd3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  1, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 0));
    // 1111 with a 3-cycle stall
    tbl.push_back(mk(0, 1, 1, 4'b1111, 0,  0, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 0,  1, 2'd3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 0,  1, 2'd3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 0,  1, 2'd3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  1, 2'd3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  1, 2'd2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  1, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  1, 2'd0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 0));
    // all-zero load
    tbl.push_back(mk(0, 1, 1, 4'b0000, 1,  0, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 0));
    // disabled all-zero load gives no pulse
    tbl.push_back(mk(0, 0, 1, 4'b0000, 1,  0, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 0));
    // overflow during SERVE of 0110
    tbl.push_back(mk(0, 1, 1, 4'b0110, 0,  0, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'b1000, 0,  1, 2'd2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  1, 2'd2, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  1, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 0));
    // load on the final handshake is lost
    tbl.push_back(mk(0, 1, 1, 4'b0001, 1,  0, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'b1000, 1,  1, 2'd0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Disable mid-SERVE of 1101 after code 3 is accepted.
    step(mk(0, 1, 1, 4'b1101, 1,  0, 2'd0, 0, 0, 0), "dis_load");
    step(mk(0, 1, 0, 4'b0000, 1,  1, 2'd3, 1, 0, 0), "dis_c3");
    step(mk(0, 0, 0, 4'b0000, 1,  1, 2'd2, 0, 0, 0), "dis_off1");
    step(mk(0, 0, 1, 4'b1000, 1,  1, 2'd2, 0, 0, 0), "dis_off2");
    step(mk(0, 1, 0, 4'b0000, 1,  1, 2'd2, 1, 0, 0), "dis_c2");
    step(mk(0, 1, 0, 4'b0000, 1,  1, 2'd0, 1, 0, 0), "dis_c0");
    step(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 0), "dis_idle");

    // Reset mid-SERVE of 1111, then a single-bit load.
    step(mk(0, 1, 1, 4'b1111, 1,  0, 2'd0, 0, 0, 0), "rst_load");
    step(mk(0, 1, 0, 4'b0000, 1,  1, 2'd3, 1, 0, 0), "rst_c3");
    step(mk(1, 1, 0, 4'b0000, 1,  1, 2'd2, 1, 0, 0), "rst_assert");
    step(mk(0, 1, 1, 4'b0001, 1,  0, 2'd0, 0, 0, 0), "rst_after");
    step(mk(0, 1, 0, 4'b0000, 1,  1, 2'd0, 1, 0, 0), "rst_c0");
    step(mk(0, 1, 0, 4'b0000, 1,  0, 2'd0, 0, 0, 0), "rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
